// File: rtl/bit32_mux3to1_arbiter.sv
// bit32_mux3to1_arbiter: round-robin arbiter/sequencer sharing one 3:1 data mux
// between three requesters and streaming the winner to a valid/ready consumer.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority req[0] > req[1] > req[2].

// Plain 3:1 mux, select 3 yields zero.
module bit32_mux3to1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] lane   [3];
  logic [WIDTH-1:0] masked [3];

  assign lane[0] = in1;
  assign lane[1] = in2;
  assign lane[2] = in3;

  // AND-OR mux: each lane is gated by its own select decode.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign masked[gi] = (sel == 2'(gi)) ? lane[gi] : '0;
  end

  assign out = masked[0] | masked[1] | masked[2];
endmodule

module bit32_mux3to1_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic [2:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        gnt_reg, gnt_next;
  logic [1:0]        sel_reg, sel_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [2:0]        pick;
  logic [2:0]        others;
  logic [2:0]        waiting;
  logic [1:0]        base_idle;
  logic [1:0]        base_grant;
  logic              cur_req;
  logic              xfer;
  logic              preempt;

  // One-hot of the first set bit of r, scanning after+1, after+2, after (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] after);
    logic [2:0] found;
    int         idx;
    found = '0;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(after) + k) % 3;
      if (r[idx[1:0]]) found = 3'b001 << idx[1:0];
    end
    return found;
  endfunction

  function automatic logic [1:0] oh2sel(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  assign cur_req   = |(req & gnt_reg);
  assign out_valid = (state_reg == GRANT) && cur_req;
  assign xfer      = out_valid && out_ready;
  assign others    = req & ~gnt_reg;
  assign preempt   = xfer && (hold_reg == HOLD_MAX) && (|waiting);

`ifdef ARB_FIXED_PRIO_EN
  // Scanning always starts after index 2, which yields 0 > 1 > 2; only
  // higher-priority (lower-index) requesters may preempt.
  assign base_idle  = 2'd2;
  assign base_grant = 2'd2;
  assign waiting    = others & ((3'b001 << sel_reg) - 3'b001);
`else
  logic [1:0] last_reg;

  assign base_idle  = last_reg;
  assign base_grant = sel_reg;
  assign waiting    = others;

  // Round-robin pointer remembers the requester that most recently gave up the grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_reg <= 2'd2;
    end else if ((state_reg == GRANT) && (!cur_req || preempt)) begin
      last_reg <= sel_reg;
    end
  end
`endif

  // Next-state and grant selection.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    hold_next  = hold_reg;
    pick       = '0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          pick       = rr_pick(req, base_idle);
          state_next = GRANT;
          gnt_next   = pick;
          sel_next   = oh2sel(pick);
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (!cur_req) begin
          // Grantee withdrew: hand over or fall back to idle (pick==0 gives sel 0).
          pick       = rr_pick(req, base_grant);
          state_next = (|pick) ? GRANT : IDLE;
          gnt_next   = pick;
          sel_next   = oh2sel(pick);
          hold_next  = '0;
        end else if (preempt) begin
          pick      = rr_pick(waiting, base_grant);
          gnt_next  = pick;
          sel_next  = oh2sel(pick);
          hold_next = '0;
        end else if (xfer && (hold_reg != HOLD_MAX)) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        sel_next   = '0;
        hold_next  = '0;
      end
    endcase
  end

  // State register; reset drops any grant without completing the beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      hold_reg  <= hold_next;
    end
  end

  assign gnt = gnt_reg;
  assign sel = sel_reg;

  bit32_mux3to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_reg),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .out (out_data)
  );
endmodule

// File: tb/tb_bit32_mux3to1_arbiter.sv
// Testbench for bit32_mux3to1_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural grant model.
module tb_bit32_mux3to1_arbiter;
  localparam int WIDTH    = 32;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       req;
  logic [WIDTH-1:0] in1, in2, in3;
  logic             out_ready;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Model: index of current grantee (-1 when idle), beats taken, pointer.
  int m_g, m_hold, m_last;

  always #5 clk = ~clk;

  bit32_mux3to1_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  function automatic int scan(input logic [2:0] r, input int after);
    for (int k = 1; k <= 3; k++) begin
      if (r[(after + k) % 3]) return (after + k) % 3;
    end
    return -1;
  endfunction

  function automatic int base_of(input int idx);
`ifdef ARB_FIXED_PRIO_EN
    return 2;
`else
    return idx;
`endif
  endfunction

  function automatic logic [2:0] exp_gnt();
    return (m_g < 0) ? 3'b000 : 3'(1 << m_g);
  endfunction

  function automatic logic [1:0] exp_sel();
    return (m_g < 0) ? 2'd0 : 2'(m_g);
  endfunction

  function automatic logic exp_valid();
    return (m_g >= 0) && req[m_g];
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    case (exp_sel())
      2'd1:    return in2;
      2'd2:    return in3;
      default: return in1;
    endcase
  endfunction

  // Apply the arbitration rules to the inputs present just before the edge.
  task automatic model_edge();
    logic [2:0] oth, wait_set;
    if (!reset_n) begin
      m_g = -1; m_hold = 0; m_last = 2;
    end else if (m_g < 0) begin
      if (req != 3'b000) begin
        m_g = scan(req, base_of(m_last)); m_hold = 0;
      end
    end else if (!req[m_g]) begin
      m_last = m_g;
      m_g    = scan(req, base_of(m_last));
      m_hold = 0;
    end else if (out_ready) begin
      oth = req;
      oth[m_g] = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      wait_set = oth & 3'((1 << m_g) - 1);
`else
      wait_set = oth;
`endif
      if (m_hold == MAX_HOLD - 1 && wait_set != 3'b000) begin
        m_last = m_g;
        m_g    = scan(wait_set, base_of(m_g));
        m_hold = 0;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 3'b000;
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt c=%0d got=%b want=000", c, gnt); end
      vectors++;
      if (sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel c=%0d got=%0d want=0", c, sel); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid c=%0d got=%b want=0", c, out_valid); end
      cycle();
    end
  endtask

  task automatic test_single();
    reset_n   = 1'b1;
    req       = 3'b001;
    in1       = 76;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency got=%b want=0", out_valid); end
    cycle();
    #1;
    vectors++;
    if (gnt !== 3'b001) begin miscompares++; $display("FAIL single_gnt got=%b want=001", gnt); end
    vectors++;
    if (sel !== 2'd0) begin miscompares++; $display("FAIL single_sel got=%0d want=0", sel); end
    vectors++;
    if (out_data !== 32'd76) begin miscompares++; $display("FAIL single_data got=%0d want=76", out_data); end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%b want=1", out_valid); end
  endtask

  task automatic test_rotation();
    logic [WIDTH-1:0] tbl [3];
    tbl[0] = 76; tbl[1] = 90; tbl[2] = 555;
    do_reset();
    req = 3'b111; in1 = tbl[0]; in2 = tbl[1]; in3 = tbl[2]; out_ready = 1'b1;
    cycle();
    for (int k = 0; k < 14; k++) begin
      #1;
      vectors++;
      if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL rot_gnt k=%0d got=%b want=%b", k, gnt, exp_gnt()); end
`ifndef ARB_FIXED_PRIO_EN
      vectors++;
      if (k < 12 && out_data !== tbl[k / 4]) begin
        miscompares++; $display("FAIL rot_data k=%0d got=%0d want=%0d", k, out_data, tbl[k / 4]);
      end
`endif
      cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 3'b010; in2 = 1023; out_ready = 1'b0;
    cycle();
    req = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (gnt !== 3'b010) begin miscompares++; $display("FAIL bp_gnt c=%0d got=%b want=010", c, gnt); end
      vectors++;
      if (out_data !== 32'd1023) begin miscompares++; $display("FAIL bp_data c=%0d got=%0d want=1023", c, out_data); end
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c=%0d got=%b want=1", c, out_valid); end
      cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL bp_release_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
`ifndef ARB_FIXED_PRIO_EN
      vectors++;
      if (gnt !== ((c < 4) ? 3'b010 : 3'b100)) begin
        miscompares++; $display("FAIL bp_hold_count c=%0d got=%b want=%b", c, gnt, (c < 4) ? 3'b010 : 3'b100);
      end
`endif
      cycle();
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 3'b100; out_ready = 1'b1;
    cycle();
    #1;
    vectors++;
    if (gnt !== 3'b100 || sel !== 2'd2) begin miscompares++; $display("FAIL drop_start got=%b/%0d want=100/2", gnt, sel); end
    req = 3'b001;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_valid got=%b want=0", out_valid); end
    cycle();
    #1;
    vectors++;
    if (gnt !== 3'b001 || sel !== 2'd0) begin miscompares++; $display("FAIL drop_handover got=%b/%0d want=001/0", gnt, sel); end
    req = 3'b000;
    cycle();
    #1;
    vectors++;
    if (gnt !== 3'b000 || sel !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL drop_idle got=%b/%0d/%b want=000/0/0", gnt, sel, out_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in1 = $urandom; in2 = $urandom; in3 = $urandom;
      #1;
      vectors++;
      if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL rand_gnt i=%0d got=%b want=%b", i, gnt, exp_gnt()); end
      vectors++;
      if (sel !== exp_sel()) begin miscompares++; $display("FAIL rand_sel i=%0d got=%0d want=%0d", i, sel, exp_sel()); end
      vectors++;
      if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, out_valid, exp_valid()); end
      vectors++;
      if (out_data !== exp_data()) begin miscompares++; $display("FAIL rand_data i=%0d got=%h want=%h", i, out_data, exp_data()); end
      $display("rand i=%0d req=%b rdy=%b gnt=%b valid=%b", i, req, out_ready, gnt, out_valid);
      cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0; req = 3'b111; out_ready = 1'b0;
    in1 = '0; in2 = '0; in3 = '0;
    m_g = -1; m_hold = 0; m_last = 2;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
